// File: rtl/rs_issue_arbiter.sv
// Issue-stage arbiter: grants the oldest ready reservation station (by ROB age)
// to one shared execute unit and holds off new grants while a multi-cycle op runs.
module rs_issue_arbiter #(
  parameter int NUM_RS     = 4,
  parameter int ROBsize    = 32,
  parameter int ROBsizeLog = $clog2(ROBsize + 1),
  parameter int MULTI_LAT  = 3
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [NUM_RS-1:0]                    rs_ready_i,
  input  logic [NUM_RS-1:0][ROBsizeLog-1:0]    rs_tag_i,
  input  logic [NUM_RS-1:0]                    rs_multi_i,
  input  logic [ROBsizeLog-1:0]                rob_head_i,
  input  logic                                 fu_stall_i,
  input  logic                                 flush_i,
  output logic [NUM_RS-1:0]                    grant_o,
  output logic                                 issue_valid_o,
  output logic [$clog2(NUM_RS)-1:0]            issue_idx_o,
  output logic [ROBsizeLog-1:0]                issue_tag_o,
  output logic                                 busy_o
);

  localparam int IDX_W = $clog2(NUM_RS);
  localparam int AGE_W = ROBsizeLog + 1;
  localparam int CNT_W = $clog2(MULTI_LAT + 1);
  localparam logic [AGE_W-1:0] ROB_SZ   = AGE_W'(ROBsize);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULTI_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ST_READY = 1'b0,
    ST_BUSY  = 1'b1
  } state_t;

  // Distance of a tag from the ROB head, modulo ROBsize; one extra bit keeps
  // tag + ROBsize from overflowing before the head is subtracted.
  function automatic logic [AGE_W-1:0] age_of(input logic [ROBsizeLog-1:0] tag,
                                              input logic [ROBsizeLog-1:0] head);
    logic [AGE_W-1:0] t;
    logic [AGE_W-1:0] h;
    t = {1'b0, tag};
    h = {1'b0, head};
    if (tag >= head) age_of = t - h;
    else             age_of = t + ROB_SZ - h;
  endfunction

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      issue_valid_q, issue_valid_d;
  logic [IDX_W-1:0]          issue_idx_q, issue_idx_d;
  logic [ROBsizeLog-1:0]     issue_tag_q, issue_tag_d;

  logic [NUM_RS-1:0][AGE_W-1:0] age;
  logic                      sel_found;
  logic [IDX_W-1:0]          sel_idx;
  logic [AGE_W-1:0]          sel_age;
  logic [ROBsizeLog-1:0]     sel_tag;
  logic                      sel_multi;
  logic                      grant_allow;
  logic                      grant_any;

  always_comb begin
    for (int k = 0; k < NUM_RS; k++) begin
      age[k] = age_of(rs_tag_i[k], rob_head_i);
    end
  end

  // Strict less-than while scanning upward makes the lower index win ties.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '1;
    sel_tag   = '0;
    sel_multi = 1'b0;
    for (int k = 0; k < NUM_RS; k++) begin
      if (rs_ready_i[k] && (!sel_found || (age[k] < sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(k);
        sel_age   = age[k];
        sel_tag   = rs_tag_i[k];
        sel_multi = rs_multi_i[k];
      end
    end
  end

  always_comb begin
    grant_allow = !reset_i && !flush_i && !fu_stall_i && (state_q == ST_READY);
    grant_any   = grant_allow && sel_found;
    grant_o     = '0;
    if (grant_any) grant_o = NUM_RS'(1) << sel_idx;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    issue_valid_d = grant_any;
    issue_idx_d   = issue_idx_q;
    issue_tag_d   = issue_tag_q;
    if (grant_any) begin
      issue_idx_d = sel_idx;
      issue_tag_d = sel_tag;
    end
    if (flush_i) begin
      state_d = ST_READY;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_READY: begin
          if (grant_any && sel_multi) begin
            state_d = ST_BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
        ST_BUSY: begin
          // Occupancy only drains on cycles the unit actually advances.
          if (!fu_stall_i) begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) state_d = ST_READY;
          end
        end
        default: begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_READY;
      cnt_q         <= '0;
      issue_valid_q <= 1'b0;
      issue_idx_q   <= '0;
      issue_tag_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      issue_valid_q <= issue_valid_d;
      issue_idx_q   <= issue_idx_d;
      issue_tag_q   <= issue_tag_d;
    end
  end

  assign issue_valid_o = issue_valid_q;
  assign issue_idx_o   = issue_idx_q;
  assign issue_tag_o   = issue_tag_q;
  assign busy_o        = (state_q == ST_BUSY);

endmodule

// File: tb/tb_rs_issue_arbiter.sv
// Bench for rs_issue_arbiter: vector table of per-cycle stimulus with expected
// combinational grant, and a queue of expected registered issue outputs.
module tb_rs_issue_arbiter;

  localparam int NRS = 4;
  localparam int RSZ = 8;
  localparam int TW  = 4;
  localparam int ML  = 3;

  logic                   clk_i;
  logic                   reset_i;
  logic [NRS-1:0]         rs_ready_i;
  logic [NRS-1:0][TW-1:0] rs_tag_i;
  logic [NRS-1:0]         rs_multi_i;
  logic [TW-1:0]          rob_head_i;
  logic                   fu_stall_i;
  logic                   flush_i;
  logic [NRS-1:0]         grant_o;
  logic                   issue_valid_o;
  logic [1:0]             issue_idx_o;
  logic [TW-1:0]          issue_tag_o;
  logic                   busy_o;

  rs_issue_arbiter #(
    .NUM_RS(NRS), .ROBsize(RSZ), .ROBsizeLog(TW), .MULTI_LAT(ML)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .rs_ready_i(rs_ready_i), .rs_tag_i(rs_tag_i),
    .rs_multi_i(rs_multi_i), .rob_head_i(rob_head_i), .fu_stall_i(fu_stall_i),
    .flush_i(flush_i), .grant_o(grant_o), .issue_valid_o(issue_valid_o),
    .issue_idx_o(issue_idx_o), .issue_tag_o(issue_tag_o), .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    string                  name;
    logic                   rst;
    logic [TW-1:0]          head;
    logic [NRS-1:0]         ready;
    logic [NRS-1:0][TW-1:0] tags;
    logic [NRS-1:0]         multi;
    logic                   stall;
    logic                   flush;
    logic [NRS-1:0]         exp_grant;
    logic                   exp_busy;
  } vec_t;

  typedef struct {
    string         name;
    logic          valid;
    logic [1:0]    idx;
    logic [TW-1:0] tag;
    logic          busy;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [1:0]    mdl_idx = '0;
  logic [TW-1:0] mdl_tag = '0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input int rst, input int head, input int ready,
                              input int t0, input int t1, input int t2, input int t3,
                              input int multi, input int stall, input int flush,
                              input int g, input int busy);
    vec_t v;
    v.name = n;  v.rst = 1'(rst);  v.head = TW'(head);  v.ready = NRS'(ready);
    v.tags[0] = TW'(t0);  v.tags[1] = TW'(t1);  v.tags[2] = TW'(t2);  v.tags[3] = TW'(t3);
    v.multi = NRS'(multi);  v.stall = 1'(stall);  v.flush = 1'(flush);
    v.exp_grant = NRS'(g);  v.exp_busy = 1'(busy);
    return v;
  endfunction

  task automatic step(input vec_t v);
    exp_t e;
    exp_t got;
    reset_i    = v.rst;
    rob_head_i = v.head;
    rs_ready_i = v.ready;
    rs_tag_i   = v.tags;
    rs_multi_i = v.multi;
    fu_stall_i = v.stall;
    flush_i    = v.flush;
    #1;
    chk({v.name, ".grant"}, 32'(grant_o), 32'(v.exp_grant));
    for (int k = 0; k < NRS; k++) begin
      if (v.exp_grant[k]) begin
        mdl_idx = 2'(k);
        mdl_tag = v.tags[k];
      end
    end
    if (v.rst) begin
      mdl_idx = '0;
      mdl_tag = '0;
    end
    e.name  = v.name;
    e.valid = |v.exp_grant;
    e.idx   = mdl_idx;
    e.tag   = mdl_tag;
    e.busy  = v.exp_busy;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    if (sb.size() == 0) begin
      chk({v.name, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      chk({got.name, ".valid"}, 32'(issue_valid_o), 32'(got.valid));
      chk({got.name, ".idx"},   32'(issue_idx_o),   32'(got.idx));
      chk({got.name, ".tag"},   32'(issue_tag_o),   32'(got.tag));
      chk({got.name, ".busy"},  32'(busy_o),        32'(got.busy));
    end
    @(negedge clk_i);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_i    = 1'b1;
    flush_i    = 1'b0;
    fu_stall_i = 1'b0;
    rob_head_i = '0;
    rs_ready_i = 4'b1111;
    rs_multi_i = 4'b1111;
    rs_tag_i   = '0;
    repeat (2) begin
      #1;
      chk("reset.grant", 32'(grant_o), 32'd0);
      @(posedge clk_i);
      #1;
      chk("reset.valid", 32'(issue_valid_o), 32'd0);
      chk("reset.idx",   32'(issue_idx_o),   32'd0);
      chk("reset.tag",   32'(issue_tag_o),   32'd0);
      chk("reset.busy",  32'(busy_o),        32'd0);
      @(negedge clk_i);
    end

    //                 name          rst hd ready   t0 t1 t2 t3 multi   st fl grant   busy
    tbl.push_back(mk("age_basic",    0, 0, 4'hF,   5, 2, 7, 3, 4'h0,   0, 0, 4'b0010, 0));
    tbl.push_back(mk("wrap",         0, 6, 4'h5,   1, 0, 7, 0, 4'h0,   0, 0, 4'b0100, 0));
    tbl.push_back(mk("tie",          0, 6, 4'hA,   0, 6, 0, 6, 4'h0,   0, 0, 4'b0010, 0));
    tbl.push_back(mk("head_mid",     0, 3, 4'hF,   2, 3, 4, 5, 4'h0,   0, 0, 4'b0010, 0));
    tbl.push_back(mk("stall_ready",  0, 0, 4'hF,   5, 2, 7, 3, 4'h0,   1, 0, 4'b0000, 0));
    tbl.push_back(mk("none_ready",   0, 0, 4'h0,   5, 2, 7, 3, 4'h0,   0, 0, 4'b0000, 0));
    tbl.push_back(mk("multi_other",  0, 0, 4'h3,   0, 1, 0, 0, 4'h2,   0, 0, 4'b0001, 0));
    tbl.push_back(mk("mc_t0",        0, 0, 4'h3,   0, 1, 0, 0, 4'h1,   0, 0, 4'b0001, 1));
    tbl.push_back(mk("mc_t1",        0, 0, 4'h2,   0, 1, 0, 0, 4'h1,   0, 0, 4'b0000, 1));
    tbl.push_back(mk("mc_t2",        0, 0, 4'h2,   0, 1, 0, 0, 4'h1,   0, 0, 4'b0000, 0));
    tbl.push_back(mk("mc_t3",        0, 0, 4'h2,   0, 1, 0, 0, 4'h1,   0, 0, 4'b0010, 0));
    tbl.push_back(mk("sb_t0",        0, 0, 4'h3,   0, 1, 0, 0, 4'h1,   0, 0, 4'b0001, 1));
    tbl.push_back(mk("sb_t1",        0, 0, 4'h2,   0, 1, 0, 0, 4'h1,   1, 0, 4'b0000, 1));
    tbl.push_back(mk("sb_t2",        0, 0, 4'h2,   0, 1, 0, 0, 4'h1,   1, 0, 4'b0000, 1));
    tbl.push_back(mk("sb_t3",        0, 0, 4'h2,   0, 1, 0, 0, 4'h1,   0, 0, 4'b0000, 1));
    tbl.push_back(mk("sb_t4",        0, 0, 4'h2,   0, 1, 0, 0, 4'h1,   0, 0, 4'b0000, 0));
    tbl.push_back(mk("sb_t5",        0, 0, 4'h2,   0, 1, 0, 0, 4'h1,   0, 0, 4'b0010, 0));
    foreach (tbl[i]) step(tbl[i]);

    // Flush in the first busy cycle releases the unit on the next edge.
    step(mk("fl_t0",   0, 0, 4'h3, 0, 1, 0, 0, 4'h1, 0, 0, 4'b0001, 1));
    step(mk("fl_t1",   0, 0, 4'h2, 0, 1, 0, 0, 4'h1, 0, 1, 4'b0000, 0));
    step(mk("fl_t2",   0, 0, 4'h2, 0, 1, 0, 0, 4'h1, 0, 0, 4'b0010, 0));
    // Flush wins over a simultaneous stall while busy.
    step(mk("fs_t0",   0, 0, 4'h3, 2, 3, 0, 0, 4'h1, 0, 0, 4'b0001, 1));
    step(mk("fs_t1",   0, 0, 4'h2, 2, 3, 0, 0, 4'h1, 1, 1, 4'b0000, 0));
    step(mk("fs_t2",   0, 0, 4'h2, 2, 3, 0, 0, 4'h1, 0, 0, 4'b0010, 0));
    // Reset wins over flush and clears the held issue fields mid-busy.
    step(mk("rb_t0",   0, 0, 4'h3, 4, 5, 0, 0, 4'h1, 0, 0, 4'b0001, 1));
    step(mk("rb_t1",   1, 0, 4'h2, 4, 5, 0, 0, 4'h1, 0, 1, 4'b0000, 0));
    step(mk("rb_t2",   0, 0, 4'h2, 4, 5, 0, 0, 4'h1, 0, 0, 4'b0010, 0));
    // Back-to-back single-cycle issue, each station dropping after its grant.
    step(mk("b2b_0",   0, 0, 4'hF, 0, 1, 2, 3, 4'h0, 0, 0, 4'b0001, 0));
    step(mk("b2b_1",   0, 0, 4'hE, 0, 1, 2, 3, 4'h0, 0, 0, 4'b0010, 0));
    step(mk("b2b_2",   0, 0, 4'hC, 0, 1, 2, 3, 4'h0, 0, 0, 4'b0100, 0));
    step(mk("b2b_3",   0, 0, 4'h8, 0, 1, 2, 3, 4'h0, 0, 0, 4'b1000, 0));
    step(mk("b2b_end", 0, 0, 4'h0, 0, 1, 2, 3, 4'h0, 0, 0, 4'b0000, 0));

    chk("sb.drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
